// File: rtl/rom_main_acc.sv
// Frame accumulator for the odd-halving ROM index stage: sums and counts odd beats per frame.
// Define ROM_ACC_SAT_EN to saturate the sum at its maximum; otherwise the sum wraps.
module rom_main_acc #(
  parameter int W  = 8,
  parameter int N  = 16,
  parameter int SW = 16,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_idx,
  input  logic          in_odd,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_sum,
  output logic [CW-1:0] out_cnt
);

  // state | meaning
  // IDLE  | no beat accepted in the current frame
  // ACC   | at least one beat accepted, frame still open
  // HOLD  | frame closed, result presented until out_ready
  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

  state_t        state, state_nxt;
  logic [SW-1:0] sum;
  logic [CW-1:0] odd_cnt;
  logic [CW-1:0] beats;
  logic          accept;
  logic          close;
  logic          drain;
  logic [SW:0]   sum_wide;
  logic [SW-1:0] sum_add;

  assign accept = in_valid & in_ready;
  assign close  = accept & (in_last | (beats == LAST_BEAT));
  assign drain  = out_valid & out_ready;

  assign sum_wide = {1'b0, sum} + (SW + 1)'(in_idx);
`ifdef ROM_ACC_SAT_EN
  assign sum_add = sum_wide[SW] ? {SW{1'b1}} : sum_wide[SW-1:0];
`else
  assign sum_add = sum_wide[SW-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = close ? HOLD : ACC;
      ACC:     if (close)  state_nxt = HOLD;
      HOLD:    if (drain)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state != HOLD);
    out_valid = (state == HOLD);
  end

  // Outputs are the accumulator registers; they only mean something in HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum     <= '0;
      odd_cnt <= '0;
      beats   <= '0;
    end else if (drain) begin
      sum     <= '0;
      odd_cnt <= '0;
      beats   <= '0;
    end else if (accept) begin
      beats <= beats + 1'b1;
      if (in_odd) begin
        sum     <= sum_add;
        odd_cnt <= odd_cnt + 1'b1;
      end
    end
  end

  assign out_sum = sum;
  assign out_cnt = odd_cnt;

endmodule

// File: tb/tb_rom_main_acc.sv
// Directed bench for rom_main_acc: default instance plus an SW=12/N=20 instance for overflow.
// Expected overflow result follows ROM_ACC_SAT_EN, same as the design.
module tb_rom_main_acc;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, in_odd, in_last;
  logic [7:0]  in_idx;
  logic        out_valid, out_ready;
  logic [15:0] out_sum;
  logic [4:0]  out_cnt;

  logic        b_in_valid, b_in_ready, b_in_odd, b_in_last;
  logic [7:0]  b_in_idx;
  logic        b_out_valid, b_out_ready;
  logic [11:0] b_out_sum;
  logic [4:0]  b_out_cnt;

  int checks;
  int failures;

  rom_main_acc #(.W(8), .N(16), .SW(16), .CW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
    .in_odd(in_odd), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cnt(out_cnt)
  );

  rom_main_acc #(.W(8), .N(20), .SW(12), .CW(5)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_idx(b_in_idx),
    .in_odd(b_in_odd), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_cnt(b_out_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer one beat and wait (bounded) until it is accepted; in_valid stays high.
  task automatic send(input logic [7:0] idx, input logic odd, input logic last);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_idx   = idx;
    in_odd   = odd;
    in_last  = last;
    for (int k = 0; k < 50 && !done; k++) begin
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain_result();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_ready", 32'(in_ready), 32'd1);
  endtask

  logic [32:0] exp_b;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    in_valid = 1'b0; in_idx = '0; in_odd = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_idx = '0; b_in_odd = 1'b0; b_in_last = 1'b0; b_out_ready = 1'b0;
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_sum", 32'(out_sum), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Partial frame of 5 odd beats, then asynchronous reset mid-frame.
    for (int i = 0; i < 5; i++) send(8'd1, 1'b1, 1'b0);
    in_valid = 1'b0;
    check("pre_rst_sum", 32'(out_sum), 32'd5);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(out_sum), 32'd0);
    check("midrst_cnt", 32'(out_cnt), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Fresh frame of 16 odd idx=1: the discarded partial frame must not leak in.
    for (int i = 0; i < 16; i++) begin
      send(8'd1, 1'b1, 1'b0);
      if (i == 14) check("n15_not_closed", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    check("rst_frame_valid", 32'(out_valid), 32'd1);
    check("rst_frame_sum", 32'(out_sum), 32'd16);
    check("rst_frame_cnt", 32'(out_cnt), 32'd16);
    drain_result();

    // 16 odd beats of idx=10.
    for (int i = 0; i < 16; i++) send(8'd10, 1'b1, 1'b0);
    in_valid = 1'b0;
    check("full_valid", 32'(out_valid), 32'd1);
    check("full_sum", 32'(out_sum), 32'd160);
    check("full_cnt", 32'(out_cnt), 32'd16);
    drain_result();

    // Alternating odd idx=3 / even idx=0x55.
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) send(8'd3, 1'b1, 1'b0);
      else            send(8'h55, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    check("alt_sum", 32'(out_sum), 32'd24);
    check("alt_cnt", 32'(out_cnt), 32'd8);
    drain_result();

    // Early close with in_last on the third beat.
    send(8'd7, 1'b1, 1'b0);
    send(8'd9, 1'b1, 1'b0);
    send(8'd11, 1'b1, 1'b1);
    check("last_valid", 32'(out_valid), 32'd1);
    check("last_sum", 32'(out_sum), 32'd27);
    check("last_cnt", 32'(out_cnt), 32'd3);
    check("last_ready", 32'(in_ready), 32'd0);

    // Backpressure in HOLD with a pending single-beat frame (idx 5, in_last).
    in_valid = 1'b1; in_idx = 8'd5; in_odd = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(out_sum), 32'd27);
      check("bp_cnt", 32'(out_cnt), 32'd3);
      check("bp_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_hs_valid", 32'(out_valid), 32'd0);
    check("bp_hs_sum", 32'(out_sum), 32'd0);
    check("bp_hs_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_sum", 32'(out_sum), 32'd5);
    check("single_cnt", 32'(out_cnt), 32'd1);
    drain_result();

    // Overflow instance: 20 odd beats of 255 into a 12-bit sum.
`ifdef ROM_ACC_SAT_EN
    exp_b = 33'd4095;
`else
    exp_b = 33'd1004;
`endif
    b_in_valid = 1'b1; b_in_idx = 8'd255; b_in_odd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("b_ready", 32'(b_in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    b_in_valid = 1'b0;
    check("ovf_valid", 32'(b_out_valid), 32'd1);
    check("ovf_sum", 32'(b_out_sum), exp_b[31:0]);
    check("ovf_cnt", 32'(b_out_cnt), 32'd20);
    b_out_ready = 1'b1;
    @(posedge clk);
    #1;
    b_out_ready = 1'b0;
    check("ovf_drain", 32'(b_out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
